hazard_controller: RTL and testbench

- Pipeline hazard and sequencing controller for the 5-stage MIPS core.
- Sits beside the forwarding unit and handles what forwarding cannot: load-use stalls, ID-stage branch operand stalls, taken-branch flushes, and sequencing of the multi-cycle multiply/divide (HI/LO) unit.
- Drives the stall/flush controls of the IF/ID/EX pipeline registers and the busy/done status of the mult/div unit.

---
 rtl/hazard_controller.sv | 166 ++++++++++++++++
 tb/tb_hazard_controller.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// -----------------------------------------------------------------------------
// hazard_controller
//
// Pipeline hazard and sequencing controller for the 5-stage MIPS core. It
// handles what the forwarding unit cannot: load-use stalls, ID-stage branch
// operand stalls, taken-branch flushes and the sequencing of the multi-cycle
// multiply/divide (HI/LO) unit.
//
// Ports
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   idRs, idRt              source registers of the instruction in ID
//   idBranch, branchTaken   ID instruction is beq/bne, and its compare result
//   idUsesHiLo              ID instruction is mfhi/mflo
//   idMdStart               ID instruction is mult/multu/div/divu
//   exRt, exMemRead         EX load destination (rt) and load flag
//   exRegWrite, exWriteReg  EX register-writing instruction and destination
//   memMemRead, memWriteReg MEM load flag and destination
//   exMdStart, exMdIsDiv    mult/div start strobe in EX, 1 = divide
//   stallF, stallD          hold PC / hold IF/ID
//   flushD, flushE          clear IF/ID (taken branch) / clear ID/EX (bubble)
//   mdBusy, mdDone, mdErr   unit not idle / HI/LO write pulse / sticky error
//
// Handshake: exMdStart is a single-cycle strobe accepted only while the unit
// is IDLE; a strobe seen in any other state is dropped and sets mdErr. The
// result is signalled by mdDone, high for exactly one cycle (state DONE).
// State is held in r_state (md_state_t) for checkers to bind to.
// -----------------------------------------------------------------------------
module hazard_controller #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] idRs,
  input  logic [4:0] idRt,
  input  logic       idBranch,
  input  logic       branchTaken,
  input  logic       idUsesHiLo,
  input  logic       idMdStart,
  input  logic [4:0] exRt,
  input  logic       exMemRead,
  input  logic       exRegWrite,
  input  logic [4:0] exWriteReg,
  input  logic       memMemRead,
  input  logic [4:0] memWriteReg,
  input  logic       exMdStart,
  input  logic       exMdIsDiv,
  output logic       stallF,
  output logic       stallD,
  output logic       flushD,
  output logic       flushE,
  output logic       mdBusy,
  output logic       mdDone,
  output logic       mdErr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } md_state_t;

  // Counter is loaded with N-1 so that BUSY lasts exactly N cycles.
  localparam logic [5:0] MULT_LOAD = 6'(MULT_CYCLES - 1);
  localparam logic [5:0] DIV_LOAD  = 6'(DIV_CYCLES - 1);

  md_state_t  r_state;
  md_state_t  w_state_nxt;
  logic [5:0] r_cnt;
  logic [5:0] w_cnt_nxt;
  logic       r_err;
  logic       w_err_nxt;

  logic w_lw_stall;
  logic w_br_stall;
  logic w_md_stall;
  logic w_stall;

  // Register matches; $zero never carries a hazard.
  logic w_exrt_rs, w_exrt_rt, w_exwr_rs, w_exwr_rt, w_memwr_rs, w_memwr_rt;

  assign w_exrt_rs  = (exRt != 5'd0)        && (exRt == idRs);
  assign w_exrt_rt  = (exRt != 5'd0)        && (exRt == idRt);
  assign w_exwr_rs  = (exWriteReg != 5'd0)  && (exWriteReg == idRs);
  assign w_exwr_rt  = (exWriteReg != 5'd0)  && (exWriteReg == idRt);
  assign w_memwr_rs = (memWriteReg != 5'd0) && (memWriteReg == idRs);
  assign w_memwr_rt = (memWriteReg != 5'd0) && (memWriteReg == idRt);

  assign w_lw_stall = exMemRead & (w_exrt_rs | w_exrt_rt);
  assign w_br_stall = idBranch &
                      ((exRegWrite & (w_exwr_rs | w_exwr_rt)) |
                       (memMemRead & (w_memwr_rs | w_memwr_rt)));
  // A start already in EX counts as busy so mfhi/mflo or a second mult/div
  // right behind it is held off before the FSM has even left IDLE.
  assign w_md_stall = (idUsesHiLo | idMdStart) &
                      ((r_state != S_IDLE) | exMdStart);
  assign w_stall    = w_lw_stall | w_br_stall | w_md_stall;

  assign stallF = w_stall;
  assign stallD = w_stall;
  assign flushE = w_stall;
  // A stalled branch must be re-evaluated next cycle, so it never flushes.
  assign flushD = idBranch & branchTaken & ~w_stall;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 6'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    // A start outside IDLE is ignored but remembered.
    w_err_nxt   = r_err | (exMdStart & (r_state != S_IDLE));
    case (r_state)
      S_IDLE: begin
        if (exMdStart) begin
          w_state_nxt = S_BUSY;
          w_cnt_nxt   = exMdIsDiv ? DIV_LOAD : MULT_LOAD;
        end
      end
      S_BUSY: begin
        if (r_cnt == 6'd0) begin
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt - 6'd1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    mdBusy = 1'b0;
    mdDone = 1'b0;
    case (r_state)
      S_BUSY: mdBusy = 1'b1;
      S_DONE: begin
        mdBusy = 1'b1;
        mdDone = 1'b1;
      end
      default: begin
        mdBusy = 1'b0;
        mdDone = 1'b0;
      end
    endcase
  end

  assign mdErr = r_err;

endmodule

// File: tb/tb_hazard_controller.sv
// -----------------------------------------------------------------------------
// tb_hazard_controller
//
// Random and directed stimulus; every cycle the driver pushes the expected
// output vector {stallF,stallD,flushD,flushE,mdBusy,mdDone,mdErr} into exp_q
// and the monitor pops and compares it on the falling edge. The mult/div
// reference is a schedule: an accepted start at rising edge s is busy after
// edges s..s+N, done after edge s+N and idle from edge s+N+1 on.
// -----------------------------------------------------------------------------
module tb_hazard_controller;

  localparam int MULT_N = 4;
  localparam int DIV_N  = 16;

  typedef struct packed {
    logic [4:0] idRs;
    logic [4:0] idRt;
    logic       idBranch;
    logic       branchTaken;
    logic       idUsesHiLo;
    logic       idMdStart;
    logic [4:0] exRt;
    logic       exMemRead;
    logic       exRegWrite;
    logic [4:0] exWriteReg;
    logic       memMemRead;
    logic [4:0] memWriteReg;
    logic       exMdStart;
    logic       exMdIsDiv;
  } in_t;

  logic clk;
  logic rst_n;
  in_t  cur;
  logic stallF, stallD, flushD, flushE, mdBusy, mdDone, mdErr;

  hazard_controller #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .idRs       (cur.idRs),
    .idRt       (cur.idRt),
    .idBranch   (cur.idBranch),
    .branchTaken(cur.branchTaken),
    .idUsesHiLo (cur.idUsesHiLo),
    .idMdStart  (cur.idMdStart),
    .exRt       (cur.exRt),
    .exMemRead  (cur.exMemRead),
    .exRegWrite (cur.exRegWrite),
    .exWriteReg (cur.exWriteReg),
    .memMemRead (cur.memMemRead),
    .memWriteReg(cur.memWriteReg),
    .exMdStart  (cur.exMdStart),
    .exMdIsDiv  (cur.exMdIsDiv),
    .stallF     (stallF),
    .stallD     (stallD),
    .flushD     (flushD),
    .flushE     (flushE),
    .mdBusy     (mdBusy),
    .mdDone     (mdDone),
    .mdErr      (mdErr)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [6:0] exp_q[$];
  int         n_vec  = 0;
  int         n_miss = 0;

  // Reference model of the mult/div unit.
  int  edge_n;
  bit  op_valid;
  int  op_start;
  int  op_len;
  bit  m_err;

  // 0 idle, 1 busy, 2 done: state after rising edge e.
  function automatic int m_state(input int e);
    if (!op_valid || e < op_start || e > op_start + op_len) return 0;
    if (e == op_start + op_len) return 2;
    return 1;
  endfunction

  function automatic bit hit(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  function automatic logic [6:0] expect_vec(input in_t v, input int st,
                                            input bit err);
    bit lw, br, md, s, fd;
    lw = v.exMemRead & (hit(v.exRt, v.idRs) | hit(v.exRt, v.idRt));
    br = v.idBranch &
         ((v.exRegWrite & (hit(v.exWriteReg, v.idRs) | hit(v.exWriteReg, v.idRt))) |
          (v.memMemRead & (hit(v.memWriteReg, v.idRs) | hit(v.memWriteReg, v.idRt))));
    md = (v.idUsesHiLo | v.idMdStart) & ((st != 0) | v.exMdStart);
    s  = lw | br | md;
    fd = v.idBranch & v.branchTaken & ~s;
    return {s, s, fd, s, (st != 0), (st == 2), err};
  endfunction

  task automatic chk(input string name, input logic [6:0] got,
                     input logic [6:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s t=%0t got=%b exp=%b (stallF,stallD,flushD,flushE,mdBusy,mdDone,mdErr)",
               name, $time, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Advances the model over the rising edge with the inputs that edge
  // sampled, then drives the next vector and queues its expected response.
  task automatic apply(input in_t v);
    @(posedge clk);
    edge_n++;
    if (cur.exMdStart) begin
      if (m_state(edge_n - 1) == 0) begin
        op_valid = 1'b1;
        op_start = edge_n;
        op_len   = cur.exMdIsDiv ? DIV_N : MULT_N;
      end else begin
        m_err = 1'b1;
      end
    end
    #1;
    cur = v;
    exp_q.push_back(expect_vec(v, m_state(edge_n), m_err));
  endtask

  function automatic in_t rnd_vec();
    in_t v;
    v.idRs        = 5'($urandom_range(0, 3));
    v.idRt        = 5'($urandom_range(0, 3));
    v.idBranch    = 1'($urandom_range(0, 1));
    v.branchTaken = 1'($urandom_range(0, 1));
    v.idUsesHiLo  = ($urandom_range(0, 3) == 0);
    v.idMdStart   = ($urandom_range(0, 3) == 0);
    v.exRt        = 5'($urandom_range(0, 3));
    v.exMemRead   = ($urandom_range(0, 2) == 0);
    v.exRegWrite  = 1'($urandom_range(0, 1));
    v.exWriteReg  = 5'($urandom_range(0, 3));
    v.memMemRead  = ($urandom_range(0, 2) == 0);
    v.memWriteReg = 5'($urandom_range(0, 3));
    v.exMdStart   = ($urandom_range(0, 11) == 0);
    v.exMdIsDiv   = 1'($urandom_range(0, 1));
    return v;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        chk("cycle", {stallF, stallD, flushD, flushE, mdBusy, mdDone, mdErr},
            exp_q.pop_front());
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t simulation did not complete", $time);
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  in_t z;
  in_t v;

  initial begin
    z        = '0;
    cur      = '0;
    edge_n   = 0;
    op_valid = 1'b0;
    op_start = 0;
    op_len   = 0;
    m_err    = 1'b0;
    rst_n    = 1'b0;
    #3;
    chk("reset_outputs", {stallF, stallD, flushD, flushE, mdBusy, mdDone, mdErr},
        7'b0);
    #9 rst_n = 1'b1;

    // Load-use: hazard, then rt = $zero.
    v = z; v.exMemRead = 1'b1; v.exRt = 5'd5; v.idRs = 5'd5; apply(v);
    v.exRt = 5'd0; v.idRs = 5'd0; apply(v);
    // Branch operand hazard vs. clean taken branch.
    v = z; v.idBranch = 1'b1; v.branchTaken = 1'b1; v.idRt = 5'd8;
    v.exRegWrite = 1'b1; v.exWriteReg = 5'd8; apply(v);
    v.exWriteReg = 5'd9; apply(v);
    v.exRegWrite = 1'b0; v.memMemRead = 1'b1; v.memWriteReg = 5'd8; apply(v);

    // Multiply with mfhi held behind it, then divide with mult behind it.
    v = z; v.exMdStart = 1'b1; v.idUsesHiLo = 1'b1; apply(v);
    v = z; v.idUsesHiLo = 1'b1;
    for (int i = 0; i < 8; i++) apply(v);
    v = z; v.exMdStart = 1'b1; v.exMdIsDiv = 1'b1; v.idMdStart = 1'b1; apply(v);
    v = z; v.idMdStart = 1'b1;
    for (int i = 0; i < 20; i++) apply(v);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) apply(rnd_vec());
    for (int i = 0; i < 20; i++) apply(z);

    // Start during BUSY: sets mdErr, original timing unaffected.
    v = z; v.exMdStart = 1'b1; apply(v);
    apply(z);
    v = z; v.exMdStart = 1'b1; v.exMdIsDiv = 1'b1; apply(v);
    for (int i = 0; i < 8; i++) apply(z);

    // Reset in the middle of BUSY.
    v = z; v.exMdStart = 1'b1; v.exMdIsDiv = 1'b1; apply(v);
    apply(z);
    apply(z);
    @(negedge clk);
    #1;
    rst_n    = 1'b0;
    cur      = z;
    op_valid = 1'b0;
    m_err    = 1'b0;
    edge_n   = 0;
    #1;
    chk("async_reset", {stallF, stallD, flushD, flushE, mdBusy, mdDone, mdErr},
        7'b0);
    @(posedge clk);
    #1;
    chk("held_reset", {stallF, stallD, flushD, flushE, mdBusy, mdDone, mdErr},
        7'b0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 24; i++) apply(z);

    @(negedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
